// File: rtl/banked_mem.sv
// ---------------------------------------------------------------------------
// banked_mem
//
// Main memory with a banked upper address window, a write-protected low
// region and a req/ready handshake with a configurable number of wait
// states. Read data is registered. It replaces the plain single-array memory
// between the address bus, the main data bus and the memory bus.
//
// Physical array layout: the unbanked region [0, WINDOW_BASE) maps 1:1. It is
// followed by NB copies of the window, each (2^WIDTH_ADDR - WINDOW_BASE)
// words long.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   addr_in      CPU address
//   bus_dir      0: main -> mem, 1: mem -> main
//   main_in      write data from the main bus
//   assert_main  active-low drive request for the main bus
//   load_main    write enable, qualified by !bus_dir
//   req          start-access strobe, sampled only while idle
//   main_out     registered read data
//   main_en      main bus drive enable (bus_dir & !assert_main)
//   bus_out      memory bus value (main_in when writing, else main_out)
//   busy         an access is in progress
//   ready        one-cycle completion pulse
//   wp_fault     one-cycle pulse with ready when a write hit the ROM region
//   bank         current bank-select value
// ---------------------------------------------------------------------------
module banked_mem #(
   parameter int unsigned WIDTH_ADDR    = 16,
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned BANK_BITS     = 2,
   parameter int unsigned WINDOW_BASE   = 32'h8000,
   parameter int unsigned ROM_SIZE      = 32'h0000,
   parameter int unsigned BANK_REG_ADDR = 32'hFFFF,
   parameter int unsigned WAIT_STATES   = 1,
   parameter int unsigned DEFAULT_VALUE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH_ADDR-1:0] addr_in,
   input  logic                  bus_dir,
   input  logic [WIDTH-1:0]      main_in,
   input  logic                  assert_main,
   input  logic                  load_main,
   input  logic                  req,
   output logic [WIDTH-1:0]      main_out,
   output logic                  main_en,
   output logic [WIDTH-1:0]      bus_out,
   output logic                  busy,
   output logic                  ready,
   output logic                  wp_fault,
   output logic [BANK_BITS-1:0]  bank
);

   localparam int unsigned NB        = 1 << BANK_BITS;
   localparam int unsigned ADDR_SPAN = 1 << WIDTH_ADDR;
   localparam int unsigned WIN_SIZE  = ADDR_SPAN - WINDOW_BASE;
   localparam int unsigned DEPTH     = WINDOW_BASE + NB * WIN_SIZE;
   localparam int unsigned PHYS_W    = $clog2(DEPTH);

   localparam logic [WIDTH_ADDR-1:0] L_WIN_BASE  = WIDTH_ADDR'(WINDOW_BASE);
   localparam logic [WIDTH_ADDR-1:0] L_BANK_REG  = WIDTH_ADDR'(BANK_REG_ADDR);
   // One extra bit so a ROM that covers the whole address space is expressible.
   localparam logic [WIDTH_ADDR:0]   L_ROM_SIZE  = (WIDTH_ADDR + 1)'(ROM_SIZE);
   localparam logic [PHYS_W-1:0]     L_PHYS_BASE = PHYS_W'(WINDOW_BASE);
   localparam logic [PHYS_W-1:0]     L_WIN_SIZE  = PHYS_W'(WIN_SIZE);
   localparam logic [WIDTH-1:0]      L_DEFAULT   = WIDTH'(DEFAULT_VALUE);
   localparam logic [3:0]            L_CNT_INIT  =
      (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StAccess,
      StDone
   } state_e;

   state_e                r_state;
   state_e                w_state_d;
   logic [3:0]            r_cnt;

   // Request captured at acceptance; the live inputs may change afterwards.
   logic [WIDTH_ADDR-1:0] r_addr;
   logic                  r_dir;
   logic                  r_load;
   logic [WIDTH-1:0]      r_data;
   logic [BANK_BITS-1:0]  r_bank_cap;

   logic [BANK_BITS-1:0]  r_bank;
   logic [WIDTH-1:0]      r_main_out;
   logic                  r_wp;

   logic                  w_accept;
   logic                  w_commit;
   logic                  w_write;
   logic                  w_read;
   logic                  w_is_bank;
   logic                  w_is_rom;
   logic                  w_mem_we;
   logic [PHYS_W-1:0]     w_phys;

   // Contents are set at time zero only; reset leaves them alone.
   logic [WIDTH-1:0]      r_mem [DEPTH] = '{default: L_DEFAULT};

   // ------------------------------------------------------------------------
   // Decode of the captured request
   // ------------------------------------------------------------------------
   assign w_write   = r_load & ~r_dir;
   assign w_read    = r_dir;
   assign w_is_bank = (r_addr == L_BANK_REG);
   assign w_is_rom  = ({1'b0, r_addr} < L_ROM_SIZE);

   always_comb begin
      w_phys = PHYS_W'(r_addr);
      if (r_addr >= L_WIN_BASE) begin
         w_phys = L_PHYS_BASE + PHYS_W'(r_bank_cap) * L_WIN_SIZE
                + PHYS_W'(r_addr - L_WIN_BASE);
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_d = r_state;
      w_accept  = 1'b0;
      w_commit  = 1'b0;
      case (r_state)
         StIdle: begin
            if (req) begin
               w_accept  = 1'b1;
               w_state_d = (WAIT_STATES == 0) ? StAccess : StWait;
            end
         end
         StWait: begin
            if (r_cnt == 4'd0) begin
               w_state_d = StAccess;
            end
         end
         StAccess: begin
            w_commit  = 1'b1;
            w_state_d = StDone;
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, holding registers, bank register and read data
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_cnt      <= 4'd0;
         r_addr     <= '0;
         r_dir      <= 1'b0;
         r_load     <= 1'b0;
         r_data     <= '0;
         r_bank_cap <= '0;
         r_bank     <= '0;
         r_main_out <= '0;
         r_wp       <= 1'b0;
      end else begin
         r_state <= w_state_d;

         if (w_accept) begin
            r_addr     <= addr_in;
            r_dir      <= bus_dir;
            r_load     <= load_main;
            r_data     <= main_in;
            r_bank_cap <= r_bank;
            r_cnt      <= L_CNT_INIT;
         end else if (r_state == StWait && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end

         if (w_commit) begin
            // The bank register shadows the array; ROM check only applies to it.
            r_wp <= w_write & ~w_is_bank & w_is_rom;
            if (w_write && w_is_bank) begin
               r_bank <= r_data[BANK_BITS-1:0];
            end
            if (w_read) begin
               r_main_out <= w_is_bank ? WIDTH'(r_bank) : r_mem[w_phys];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Array write port; reset gating keeps an aborted access from committing
   // ------------------------------------------------------------------------
   assign w_mem_we = w_commit & w_write & ~w_is_bank & ~w_is_rom & ~rst;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_phys] <= r_data;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy     = (r_state != StIdle);
   assign ready    = (r_state == StDone);
   assign wp_fault = (r_state == StDone) & r_wp;
   assign bank     = r_bank;
   assign main_out = r_main_out;
   assign bus_out  = !bus_dir ? main_in : r_main_out;
   assign main_en  = bus_dir & ~assert_main;

endmodule

// File: tb/tb_banked_mem.sv
// Bench for banked_mem: index 1 is a WAIT_STATES=1 / ROM_SIZE=0x100 part,
// index 0 is a WAIT_STATES=0 part with no ROM.
module tb_banked_mem;

   logic        clk;
   logic        rst;
   logic [15:0] addr_in     [2];
   logic        bus_dir     [2];
   logic [7:0]  main_in     [2];
   logic        assert_main [2];
   logic        load_main   [2];
   logic        req         [2];
   logic [7:0]  main_out    [2];
   logic        main_en     [2];
   logic [7:0]  bus_out     [2];
   logic        busy        [2];
   logic        ready       [2];
   logic        wp_fault    [2];
   logic [1:0]  bank        [2];

   int n_checks = 0;
   int n_err    = 0;

   banked_mem #(
      .WAIT_STATES (1),
      .ROM_SIZE    (32'h0100)
   ) u_dut_ws1 (
      .clk         (clk),
      .rst         (rst),
      .addr_in     (addr_in[1]),
      .bus_dir     (bus_dir[1]),
      .main_in     (main_in[1]),
      .assert_main (assert_main[1]),
      .load_main   (load_main[1]),
      .req         (req[1]),
      .main_out    (main_out[1]),
      .main_en     (main_en[1]),
      .bus_out     (bus_out[1]),
      .busy        (busy[1]),
      .ready       (ready[1]),
      .wp_fault    (wp_fault[1]),
      .bank        (bank[1])
   );

   banked_mem #(
      .WAIT_STATES (0)
   ) u_dut_ws0 (
      .clk         (clk),
      .rst         (rst),
      .addr_in     (addr_in[0]),
      .bus_dir     (bus_dir[0]),
      .main_in     (main_in[0]),
      .assert_main (assert_main[0]),
      .load_main   (load_main[0]),
      .req         (req[0]),
      .main_out    (main_out[0]),
      .main_en     (main_en[0]),
      .bus_out     (bus_out[0]),
      .busy        (busy[0]),
      .ready       (ready[0]),
      .wp_fault    (wp_fault[0]),
      .bank        (bank[0])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model of the WS=1 / ROM=0x100 part ----------------
   logic [7:0] m_mem [int];
   int         m_bank = 0;
   logic [7:0] m_mo   = 8'h00;

   function automatic int phys(input int a, input int b);
      if (a < 'h8000) return a;
      return 'h8000 + b * 'h8000 + (a - 'h8000);
   endfunction

   task automatic model_apply(input logic [15:0] a, input logic d, input logic ld,
                              input logic [7:0] dat, output logic exp_wp);
      int p;
      p      = phys(int'(a), m_bank);
      exp_wp = 1'b0;
      if (d) begin
         if (a == 16'hFFFF) m_mo = 8'(m_bank);
         else               m_mo = m_mem.exists(p) ? m_mem[p] : 8'h00;
      end else if (ld) begin
         if (a == 16'hFFFF)      m_bank = int'(dat[1:0]);
         else if (a < 16'h0100)  exp_wp = 1'b1;
         else                    m_mem[p] = dat;
      end
   endtask

   // One handshake. lat = edges from the sampling edge to the edge that raised
   // ready (40 if it never came); ok = busy held and no stray wp_fault before
   // ready; tail_ok = ready and busy both low one edge later.
   task automatic access(input int s, input logic [15:0] a, input logic d, input logic ld,
                         input logic [7:0] dat, output int lat, output logic wp,
                         output logic ok, output logic tail_ok);
      @(negedge clk);
      addr_in[s] = a; bus_dir[s] = d; load_main[s] = ld; main_in[s] = dat; req[s] = 1'b1;
      @(posedge clk);
      #1;
      req[s] = 1'b0;
      addr_in[s] = 16'($urandom); main_in[s] = 8'($urandom);
      bus_dir[s] = 1'($urandom); load_main[s] = 1'($urandom);
      lat = 0; wp = 1'b0; ok = busy[s];
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (ready[s]) begin
            wp = wp_fault[s];
            break;
         end
         if (!busy[s] || wp_fault[s]) ok = 1'b0;
      end
      @(posedge clk);
      #1;
      tail_ok = !ready[s] && !busy[s];
   endtask

   // Access on part 1 checked against the model.
   task automatic op1(input string tag, input logic [15:0] a, input logic d, input logic ld,
                      input logic [7:0] dat);
      int lat; logic wp, ok, tail_ok, exp_wp;
      model_apply(a, d, ld, dat, exp_wp);
      access(1, a, d, ld, dat, lat, wp, ok, tail_ok);
      check({tag, " latency"}, lat, 2);
      check({tag, " busy"}, ok, 1);
      check({tag, " pulse"}, tail_ok, 1);
      check({tag, " wp_fault"}, wp, exp_wp);
      check({tag, " main_out"}, main_out[1], m_mo);
      check({tag, " bank"}, bank[1], m_bank[1:0]);
   endtask

   typedef struct {
      logic [15:0] a;
      logic        d;
      logic        ld;
      logic [7:0]  dat;
      logic [7:0]  mo;
      logic        wp;
      logic [1:0]  bk;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int lat; logic wp, ok, tail_ok, exp_wp;
      int busy_exp  [7];
      int ready_exp [7];
      logic [15:0] ra;

      tbl[0]  = '{16'h1234, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b0, 2'd0};
      tbl[1]  = '{16'h1234, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 2'd0};
      tbl[2]  = '{16'hFFFF, 1'b0, 1'b1, 8'h02, 8'h5A, 1'b0, 2'd2};
      tbl[3]  = '{16'h8000, 1'b0, 1'b1, 8'hAA, 8'h5A, 1'b0, 2'd2};
      tbl[4]  = '{16'hFFFF, 1'b0, 1'b1, 8'h01, 8'h5A, 1'b0, 2'd1};
      tbl[5]  = '{16'h8000, 1'b0, 1'b1, 8'hBB, 8'h5A, 1'b0, 2'd1};
      tbl[6]  = '{16'h8000, 1'b1, 1'b0, 8'h00, 8'hBB, 1'b0, 2'd1};
      tbl[7]  = '{16'hFFFF, 1'b0, 1'b1, 8'h02, 8'hBB, 1'b0, 2'd2};
      tbl[8]  = '{16'h8000, 1'b1, 1'b0, 8'h00, 8'hAA, 1'b0, 2'd2};
      tbl[9]  = '{16'hFFFF, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 2'd2};
      tbl[10] = '{16'h0010, 1'b0, 1'b1, 8'hFF, 8'h02, 1'b1, 2'd2};
      tbl[11] = '{16'h0010, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2'd2};
      tbl[12] = '{16'h0300, 1'b0, 1'b0, 8'h44, 8'h00, 1'b0, 2'd2};

      for (int s = 0; s < 2; s++) begin
         addr_in[s] = '0; bus_dir[s] = 1'b0; main_in[s] = '0;
         assert_main[s] = 1'b1; load_main[s] = 1'b0; req[s] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", busy[1], 0);
      check("reset ready", ready[1], 0);
      check("reset wp_fault", wp_fault[1], 0);
      check("reset bank", bank[1], 0);
      check("reset main_out", main_out[1], 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 13; i++) begin
         model_apply(tbl[i].a, tbl[i].d, tbl[i].ld, tbl[i].dat, exp_wp);
         access(1, tbl[i].a, tbl[i].d, tbl[i].ld, tbl[i].dat, lat, wp, ok, tail_ok);
         check($sformatf("vec%0d latency", i), lat, 2);
         check($sformatf("vec%0d busy", i), ok, 1);
         check($sformatf("vec%0d pulse", i), tail_ok, 1);
         check($sformatf("vec%0d wp_fault", i), wp, tbl[i].wp);
         check($sformatf("vec%0d main_out", i), main_out[1], tbl[i].mo);
         check($sformatf("vec%0d bank", i), bank[1], tbl[i].bk);
      end

      // req after acceptance and in DONE must be ignored
      busy_exp  = '{1, 1, 1, 0, 0, 0, 0};
      ready_exp = '{0, 0, 1, 0, 0, 0, 0};
      @(negedge clk);
      addr_in[1] = 16'h1234; bus_dir[1] = 1'b1; load_main[1] = 1'b0; req[1] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("ignore busy@%0d", k), busy[1], busy_exp[k]);
         check($sformatf("ignore ready@%0d", k), ready[1], ready_exp[k]);
         req[1] = (k + 1 == 1) || (k + 1 == 3);
      end
      model_apply(16'h1234, 1'b1, 1'b0, 8'h00, exp_wp);
      check("ignore main_out", main_out[1], m_mo);

      // Randomized traffic against the model
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 4))
            0:       ra = 16'($urandom_range(0, 'h3FF));
            1:       ra = 16'h8000 + 16'($urandom_range(0, 7));
            2:       ra = 16'hFFF8 + 16'($urandom_range(0, 6));
            3:       ra = 16'hFFFF;
            default: ra = 16'($urandom);
         endcase
         op1($sformatf("rnd%0d", i), ra, 1'($urandom), 1'($urandom), 8'($urandom));
      end

      // Reset during WAIT of a write aborts it
      op1("pre-abort write", 16'h0200, 1'b0, 1'b1, 8'h11);
      op1("bank to 3", 16'hFFFF, 1'b0, 1'b1, 8'h03);
      op1("main_out nonzero", 16'h0200, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      addr_in[1] = 16'h0200; bus_dir[1] = 1'b0; load_main[1] = 1'b1;
      main_in[1] = 8'h77; req[1] = 1'b1;
      @(posedge clk);
      #1;
      req[1] = 1'b0;
      check("abort in wait", busy[1], 1);
      rst = 1'b1;
      #1;
      check("abort busy", busy[1], 0);
      check("abort bank", bank[1], 0);
      check("abort main_out", main_out[1], 0);
      @(negedge clk);
      rst = 1'b0;
      m_bank = 0;
      m_mo   = 8'h00;
      begin
         int readies = 0;
         for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (ready[1] || wp_fault[1]) readies++;
         end
         check("abort no ready", readies, 0);
      end
      op1("after abort read", 16'h0200, 1'b1, 1'b0, 8'h00);
      check("after abort value", main_out[1], 8'h11);

      // WAIT_STATES=0 part
      @(negedge clk);
      bus_dir[0] = 1'b0; main_in[0] = 8'h3C;
      #1;
      check("ws0 bus_out write dir", bus_out[0], 8'h3C);
      bus_dir[0] = 1'b1; assert_main[0] = 1'b0;
      #1;
      check("ws0 main_en on", main_en[0], 1);
      check("ws0 bus_out read dir", bus_out[0], 8'h00);
      assert_main[0] = 1'b1;
      #1;
      check("ws0 main_en off", main_en[0], 0);
      access(0, 16'h0040, 1'b0, 1'b1, 8'h99, lat, wp, ok, tail_ok);
      check("ws0 write latency", lat, 1);
      check("ws0 write wp_fault", wp, 0);
      check("ws0 write pulse", tail_ok, 1);
      access(0, 16'h0040, 1'b1, 1'b0, 8'h00, lat, wp, ok, tail_ok);
      check("ws0 read latency", lat, 1);
      check("ws0 read busy", ok, 1);
      check("ws0 read main_out", main_out[0], 8'h99);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/banked_mem.md
Name: banked_mem

Overview:
- Successor to the single-array main memory: parametrised RAM with a banked upper window and a write-protected low (ROM) region.
- Adds a bank-select register and a request/ready handshake with configurable wait states, so slower modelled parts can sit on the same main bus.
- Read data is registered rather than combinational.
- Sits between the address bus, the main data bus and the memory bus, in place of the plain memory.

Parameters:
- WIDTH_ADDR, 16, CPU address width.
- WIDTH, 8, data width.
- BANK_BITS, 2, bank register width; number of banks NB = 2^BANK_BITS.
- WINDOW_BASE, 16'h8000, first banked CPU address; addresses below it are unbanked.
- ROM_SIZE, 16'h0000, CPU addresses below this are write-protected; 0 means no protection.
- BANK_REG_ADDR, 16'hFFFF, CPU address of the bank-select register.
- WAIT_STATES, 1, extra cycles before each access commits; range 0..15.
- DEFAULT_VALUE, 0, initial contents of every array word.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_in  in  WIDTH_ADDR  CPU address.
- bus_dir  in  1  low = main -> mem, high = mem -> main.
- main_in  in  WIDTH  write data from the main bus.
- assert_main  in  1  active-low assert request, same sense as the existing memory.
- load_main  in  1  write enable, qualified by !bus_dir.
- req  in  1  start-access strobe.
- main_out  out  WIDTH  registered read data.
- main_en  out  1  main bus drive enable.
- bus_out  out  WIDTH  memory bus value.
- busy  out  1  an access is in progress.
- ready  out  1  one-cycle completion pulse.
- wp_fault  out  1  one-cycle pulse: a write was rejected.
- bank  out  BANK_BITS  current bank-select value.

Behaviour:
- Reset values (while rst high): state IDLE, busy 0, ready 0, wp_fault 0, bank 0, main_out 0, wait counter 0.
  - Array contents are not altered by reset; they are DEFAULT_VALUE at time zero only.
- Array depth: WINDOW_BASE + NB*(2^WIDTH_ADDR - WINDOW_BASE).
- Physical address:
  - a < WINDOW_BASE: phys = a.
  - otherwise: phys = WINDOW_BASE + bank*(2^WIDTH_ADDR - WINDOW_BASE) + (a - WINDOW_BASE).
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - IDLE: when req=1, capture addr_in, bus_dir, load_main, main_in and the current bank into holding registers.
    - Next state is WAIT if WAIT_STATES>0, else ACCESS.
    - The counter loads WAIT_STATES-1.
  - WAIT: decrement the counter; go to ACCESS when it reads 0.
  - ACCESS: perform the operation on the captured values; go to DONE.
  - DONE: ready=1 (and wp_fault if applicable); go to IDLE.
- Timing:
  - ready is high for exactly one cycle, starting WAIT_STATES+1 edges after the edge that sampled req.
  - busy = 1 in WAIT, ACCESS and DONE.
- Operations at the ACCESS edge:
  - Write (captured load & !dir):
    - If the captured address equals BANK_REG_ADDR: bank <= main_in[BANK_BITS-1:0]; the array is unchanged.
    - Else if the captured address < ROM_SIZE: no write; wp_fault pulses in DONE.
    - Otherwise: array[phys] <= captured main_in.
  - Read (captured dir=1):
    - main_out <= array[phys].
    - If the captured address is BANK_REG_ADDR, main_out <= bank zero-extended instead.
  - A capture with dir=0 and load=0 is a no-op that still completes with ready.
- main_out holds its value until the next read completes; writes never change it.
- The bank value used is the one captured at req.
  - A bank write takes effect for requests sampled after its ACCESS edge.
- req while busy is ignored, including in DONE; there is no queueing. The earliest next acceptance is the cycle after DONE.
- Inputs are not required stable after the sampling edge.
- bus_out = !bus_dir ? main_in : main_out (combinational on the live bus_dir).
- main_en = bus_dir & !assert_main (combinational, independent of the FSM).
- Reset asserted mid-access:
  - Aborts immediately; returns to IDLE.
  - If reset hits before the ACCESS edge, no write is committed.
  - No ready or wp_fault pulse is emitted for the aborted access.

Test Plan:
- WAIT_STATES=1: write 8'h5A to 16'h1234, then read it back.
  - Expect ready exactly 2 edges after each req edge, and main_out=8'h5A after the read.
- Write 8'h02 to BANK_REG_ADDR; write 8'hAA to 16'h8000; write bank 1; write 8'hBB to 16'h8000.
  - Read 16'h8000 -> 8'hBB; switch to bank 2, read -> 8'hAA.
  - Reading BANK_REG_ADDR returns 8'h02.
- ROM_SIZE=16'h0100: write 8'hFF to 16'h0010.
  - Expect wp_fault pulse coincident with ready; a subsequent read of 16'h0010 returns DEFAULT_VALUE.
- Pulse req again on the cycle after acceptance and in the DONE cycle.
  - Both are ignored: exactly one ready, and busy stays high continuously until IDLE.
- Assert rst during WAIT of a write of 8'h77 to 16'h0200.
  - No ready pulse; read of 16'h0200 returns its prior value; bank=0 and main_out=0 after reset.
- WAIT_STATES=0: bus_dir=0 with main_in=8'h3C gives bus_out=8'h3C combinationally.
  - A read completes with ready one edge after the req edge.
